// File: rtl/vga_sync_decoder_if.sv
// Bundles the sampled VGA timing stream and the decoder's recovered-coordinate/status outputs.
// The master side drives the timing stream; the slave side is the decoder.
interface vga_sync_decoder_if;
   logic       pix_ce;
   logic       hs_n;
   logic       vs_n;
   logic       blank_n;
   logic [9:0] rx_x;
   logic [9:0] rx_y;
   logic       pix_valid;
   logic       frame_start;
   logic       locked;
   logic       sync_err;

   modport master (
      output pix_ce, hs_n, vs_n, blank_n,
      input  rx_x, rx_y, pix_valid, frame_start, locked, sync_err
   );

   modport slave (
      input  pix_ce, hs_n, vs_n, blank_n,
      output rx_x, rx_y, pix_valid, frame_start, locked, sync_err
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: validates line/frame geometry of an incoming HS/VS/BLANK_N
// stream, tracks lock, and recovers the column/row of each active pixel.
module vga_sync_decoder #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input logic Clk,
   input logic Reset,
   vga_sync_decoder_if.slave bus
);

   localparam logic [10:0] H_GOOD    = 11'(H_TOTAL);
   localparam logic [10:0] V_GOOD    = 11'(V_TOTAL);
   localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t     state;
   logic       hs_prev;
   logic       vs_prev;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic [9:0] x_cnt;
   logic [9:0] y_cnt;
   logic       line_act;
   logic [7:0] good_cnt;

   logic [9:0] rx_x_q;
   logic [9:0] rx_y_q;
   logic       pix_valid_q;
   logic       frame_start_q;
   logic       locked_q;
   logic       sync_err_q;

   logic       hs_fall;
   logic       vs_fall;
   logic       line_good;
   logic       frame_good;
   logic       geom_err;
   logic       pix_take;

   // Saturating at full scale guarantees a stalled sync can never alias onto a good count.
   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

   always_comb begin
      hs_fall    = bus.pix_ce & hs_prev & ~bus.hs_n;
      vs_fall    = bus.pix_ce & vs_prev & ~bus.vs_n;
      line_good  = ({1'b0, h_cnt} + 11'd1) == H_GOOD;
      frame_good = ({1'b0, v_cnt} + {10'd0, hs_fall}) == V_GOOD;
      geom_err   = (hs_fall & ~line_good) | (vs_fall & ~frame_good);
      pix_take   = bus.pix_ce & bus.blank_n & locked_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hs_prev  <= 1'b1;
         vs_prev  <= 1'b1;
         h_cnt    <= '0;
         v_cnt    <= '0;
         x_cnt    <= '0;
         y_cnt    <= '0;
         line_act <= 1'b0;
      end else if (bus.pix_ce) begin
         hs_prev <= bus.hs_n;
         vs_prev <= bus.vs_n;
         h_cnt   <= hs_fall ? 10'd0 : sat_inc(h_cnt);

         if (vs_fall)
            v_cnt <= '0;
         else if (hs_fall)
            v_cnt <= sat_inc(v_cnt);

         if (hs_fall)
            x_cnt <= '0;
         else if (bus.blank_n)
            x_cnt <= x_cnt + 10'd1;

         // A row only advances if it actually carried active video, so blank lines are skipped.
         if (vs_fall) begin
            y_cnt    <= '0;
            line_act <= 1'b0;
         end else if (hs_fall && line_act) begin
            y_cnt    <= y_cnt + 10'd1;
            line_act <= 1'b0;
         end else if (bus.blank_n) begin
            line_act <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= HUNT;
         good_cnt      <= '0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
         pix_valid_q   <= 1'b0;
         rx_x_q        <= '0;
         rx_y_q        <= '0;
      end else begin
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
         pix_valid_q   <= pix_take;
         if (pix_take) begin
            rx_x_q <= x_cnt;
            rx_y_q <= y_cnt;
         end

         if (bus.pix_ce) begin
            case (state)
               HUNT: begin
                  if (vs_fall) begin
                     state    <= SYNC;
                     good_cnt <= '0;
                  end
               end
               SYNC: begin
                  if (geom_err) begin
                     sync_err_q <= 1'b1;
                     state      <= HUNT;
                  end else if (vs_fall) begin
                     good_cnt <= good_cnt + 8'd1;
                     if (good_cnt == LOCK_LAST) begin
                        state         <= LOCKED;
                        locked_q      <= 1'b1;
                        frame_start_q <= 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (geom_err) begin
                     sync_err_q <= 1'b1;
                     locked_q   <= 1'b0;
                     state      <= HUNT;
                  end else if (vs_fall) begin
                     frame_start_q <= 1'b1;
                  end
               end
               default: begin
                  state    <= HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.rx_x        = rx_x_q;
   assign bus.rx_y        = rx_y_q;
   assign bus.pix_valid   = pix_valid_q;
   assign bus.frame_start = frame_start_q;
   assign bus.locked      = locked_q;
   assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a reduced 32x8-active / 40x12-total raster so
// that many whole frames fit in a short run; pix_ce strobes every second Clk.
module tb_vga_sync_decoder;

   localparam int HT     = 40;
   localparam int VT     = 12;
   localparam int HACT   = 32;
   localparam int VACT   = 8;
   localparam int HS_BEG = 34;
   localparam int HS_END = 38;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   always #10 Clk = ~Clk;

   vga_sync_decoder_if bus();

   vga_sync_decoder #(
      .H_TOTAL    (HT),
      .V_TOTAL    (VT),
      .LOCK_FRAMES(2)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   typedef struct {
      logic       pv;
      logic       fs;
      logic       se;
      logic [9:0] x;
      logic [9:0] y;
   } evt_t;

   evt_t exp_q[$];
   evt_t mon_e;
   int   n_cmp     = 0;
   int   n_err     = 0;
   int   n_pix_exp = 0;
   int   n_pix_got = 0;

   function automatic logic hsv(input int h);
      return !(h >= HS_BEG && h < HS_END);
   endfunction

   function automatic logic vsv(input int v);
      return !(v == 9 || v == 10);
   endfunction

   function automatic logic blv(input int h, input int v);
      return (h < HACT) && (v < VACT);
   endfunction

   task automatic pushEvt(input logic pv, input logic fs, input logic se, input int x, input int y);
      evt_t e;
      e.pv = pv;
      e.fs = fs;
      e.se = se;
      e.x  = 10'(x);
      e.y  = 10'(y);
      exp_q.push_back(e);
      if (pv) n_pix_exp++;
   endtask

   // One pixel sample, then one idle Clk with the sync inputs deliberately inverted.
   task automatic applyStimulus(input logic hs, input logic vs, input logic bl, input logic rst);
      bus.pix_ce  = 1'b1;
      bus.hs_n    = hs;
      bus.vs_n    = vs;
      bus.blank_n = bl;
      Reset       = rst;
      @(posedge Clk);
      #1;
      bus.pix_ce  = 1'b0;
      bus.hs_n    = ~hs;
      bus.vs_n    = ~vs;
      bus.blank_n = 1'b1;
      Reset       = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string nm, input int ex, input int ey, input logic elk);
      logic [23:0] got;
      logic [23:0] want;
      got  = {bus.rx_x, bus.rx_y, bus.locked, bus.pix_valid, bus.frame_start, bus.sync_err};
      want = {10'(ex), 10'(ey), elk, 3'b000};
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("[TB] FAIL %s: got x=%0d y=%0d locked=%0b pv/fs/se=%b%b%b, want x=%0d y=%0d locked=%0b pv/fs/se=000",
                  nm, bus.rx_x, bus.rx_y, bus.locked, bus.pix_valid, bus.frame_start, bus.sync_err,
                  ex, ey, elk);
      end
   endtask

   // A frame starts at the VS falling sample (line 9) and runs to the end of line 8.
   // ev_vs: 0 none, 1 frame_start, 2 sync_err at that first sample. lock_exp is the lock
   // state after it. mod_kind 1 drops the last sample of line mod_line, 2 appends 1024
   // HS-high samples to it; either is flagged at the HS fall of the following line.
   task automatic applyFrame(input string nm, input int n_lines, input int ev_vs, input bit lock_exp,
                             input int mod_line, input int mod_kind, input bit err_exp,
                             input int rst_line);
      int   v;
      int   hlen;
      bit   lk;
      logic rst;
      lk = lock_exp;
      for (int li = 0; li < n_lines; li++) begin
         v    = (li < n_lines - 9) ? 9 + li : li - (n_lines - 9);
         hlen = (v == mod_line && mod_kind == 1) ? HT - 1 : HT;
         for (int h = 0; h < hlen; h++) begin
            rst = 1'b0;
            if (li == 0 && h == 0) begin
               if (ev_vs == 1) pushEvt(1'b0, 1'b1, 1'b0, 0, 0);
               else if (ev_vs == 2) pushEvt(1'b0, 1'b0, 1'b1, 0, 0);
            end
            if (err_exp && v == mod_line + 1 && h == HS_BEG) begin
               pushEvt(1'b0, 1'b0, 1'b1, 0, 0);
               lk = 1'b0;
            end
            if (v == rst_line && h == 10) begin
               rst = 1'b1;
               lk  = 1'b0;
            end
            if (blv(h, v) && lk && !rst) pushEvt(1'b1, 1'b0, 1'b0, h, v);
            applyStimulus(hsv(h), vsv(v), blv(h, v), rst);
         end
         if (v == mod_line && mod_kind == 2)
            repeat (1024) applyStimulus(1'b1, vsv(v), 1'b0, 1'b0);
      end
      $display("[TB] frame %s sent", nm);
   endtask

   always @(negedge Clk) begin
      if (bus.pix_valid || bus.frame_start || bus.sync_err) begin
         n_cmp++;
         if (bus.pix_valid) n_pix_got++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("[TB] FAIL unexpected_event: got pv/fs/se=%b%b%b x=%0d y=%0d, want no event",
                     bus.pix_valid, bus.frame_start, bus.sync_err, bus.rx_x, bus.rx_y);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.pix_valid, bus.frame_start, bus.sync_err} !== {mon_e.pv, mon_e.fs, mon_e.se} ||
                (mon_e.pv && (bus.rx_x !== mon_e.x || bus.rx_y !== mon_e.y))) begin
               n_err++;
               $display("[TB] FAIL event: got pv/fs/se=%b%b%b x=%0d y=%0d, want pv/fs/se=%b%b%b x=%0d y=%0d",
                        bus.pix_valid, bus.frame_start, bus.sync_err, bus.rx_x, bus.rx_y,
                        mon_e.pv, mon_e.fs, mon_e.se, mon_e.x, mon_e.y);
            end
         end
      end
   end

   initial begin
      bus.pix_ce  = 1'b0;
      bus.hs_n    = 1'b1;
      bus.vs_n    = 1'b1;
      bus.blank_n = 1'b0;
      Reset       = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("reset_state", 0, 0, 1'b0);
      Reset = 1'b0;

      // Join the stream mid-frame.
      for (int v = 3; v < VT - 3; v++)
         for (int h = 0; h < HT; h++)
            applyStimulus(hsv(h), vsv(v), blv(h, v), 1'b0);

      applyFrame("F1", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      checkOutput("after_vs1", 0, 0, 1'b0);
      applyFrame("F2", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      checkOutput("after_vs2", 0, 0, 1'b0);
      applyFrame("F3", 12, 1, 1'b1, -1, 0, 1'b0, -1);
      checkOutput("locked_vs3", HACT - 1, VACT - 1, 1'b1);

      applyFrame("F4_short_line", 12, 1, 1'b1, 3, 1, 1'b1, -1);
      checkOutput("after_short_line", HACT - 1, 4, 1'b0);
      applyFrame("F5", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      applyFrame("F6", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      applyFrame("F7", 12, 1, 1'b1, -1, 0, 1'b0, -1);
      checkOutput("relock_short_line", HACT - 1, VACT - 1, 1'b1);

      applyFrame("F8_11_lines", 11, 1, 1'b1, -1, 0, 1'b0, -1);
      checkOutput("locked_in_short_frame", HACT - 1, VACT - 1, 1'b1);
      applyFrame("F9", 12, 2, 1'b0, -1, 0, 1'b0, -1);
      checkOutput("after_short_frame", HACT - 1, VACT - 1, 1'b0);
      applyFrame("F10", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      applyFrame("F11", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      applyFrame("F12", 12, 1, 1'b1, -1, 0, 1'b0, -1);

      applyFrame("F13_hs_stall", 12, 1, 1'b1, 3, 2, 1'b1, -1);
      checkOutput("after_hs_stall", HACT - 1, 4, 1'b0);
      applyFrame("F14", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      applyFrame("F15", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      applyFrame("F16", 12, 1, 1'b1, -1, 0, 1'b0, -1);
      checkOutput("relock_hs_stall", HACT - 1, VACT - 1, 1'b1);

      applyFrame("F17_reset", 12, 1, 1'b1, -1, 0, 1'b0, 2);
      checkOutput("after_mid_reset", 0, 0, 1'b0);
      applyFrame("F18", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      checkOutput("reset_vs1", 0, 0, 1'b0);
      applyFrame("F19", 12, 0, 1'b0, -1, 0, 1'b0, -1);
      checkOutput("reset_vs2", 0, 0, 1'b0);
      applyFrame("F20", 12, 1, 1'b1, -1, 0, 1'b0, -1);
      checkOutput("relock_after_reset", HACT - 1, VACT - 1, 1'b1);

      repeat (4) @(posedge Clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("[TB] FAIL missing_events: got %0d expected events never seen, want 0", exp_q.size());
      end
      n_cmp++;
      if (n_pix_got != n_pix_exp) begin
         n_err++;
         $display("[TB] FAIL pix_valid_total: got %0d, want %0d", n_pix_got, n_pix_exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. The block samples a VGA timing stream (active-low HS, VS and BLANK_N) on pixel-enable strobes. It checks the stream against the expected 640x480 line and frame geometry and recovers pixel coordinates. It is used by the hit-detection and light-gun path, and as a self-check monitor on the generated VGA_HS, VGA_VS and VGA_BLANK_N.

Parameters:
H_TOTAL, 800, pixel samples between consecutive HS falling edges
V_TOTAL, 525, HS falling edges between consecutive VS falling edges
LOCK_FRAMES, 2, consecutive good frames required to declare lock

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
pix_ce  in  1  one-Clk pixel strobe; inputs are sampled only when this is 1
hs_n  in  1  horizontal sync, active low
vs_n  in  1  vertical sync, active low
blank_n  in  1  1 = active video pixel
rx_x  out  10  recovered column of the current active pixel
rx_y  out  10  recovered row of the current active pixel
pix_valid  out  1  rx_x and rx_y are valid for this pixel
frame_start  out  1  one-Clk pulse on every accepted VS falling edge
locked  out  1  stream matches the geometry
sync_err  out  1  one-Clk pulse on a geometry violation

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-high (Reset). Every register is updated only on a Clk rising edge.
- When pix_ce = 0, no state changes, and pix_valid, frame_start and sync_err are 0 on the next cycle.
- Edge detection:
  - hs_prev and vs_prev hold the previous sampled values and reset to 1.
  - hs_fall = pix_ce & hs_prev & ~hs_n; vs_fall likewise.
- h_cnt (10 bits, saturates at 1023):
  - Set to 0 on hs_fall.
  - Otherwise incremented on each pix_ce.
  - Line check at hs_fall: the line is good iff h_cnt + 1 == H_TOTAL.
- v_cnt (10 bits, saturates at 1023):
  - Incremented on each hs_fall.
  - Set to 0 on vs_fall.
  - Frame check at vs_fall counts the coincident hs_fall: the frame is good iff (v_cnt + hs_fall) == V_TOTAL.
- x/y recovery:
  - x_cnt is cleared on hs_fall and incremented after each sample with blank_n = 1.
  - line_act is set by any blank_n = 1 sample.
  - On hs_fall with line_act = 1: y_cnt is incremented and line_act is cleared.
  - On vs_fall: y_cnt = 0 and line_act = 0. vs_fall takes priority over hs_fall.
- Output registers, 1-Clk latency from the sampling cycle:
  - pix_valid = pix_ce & blank_n & locked.
  - rx_x = x_cnt and rx_y = y_cnt, both pre-increment.
  - Outputs hold their value when pix_valid = 0.
- State machine, states HUNT, SYNC, LOCKED:
  - HUNT: the line check is ignored (first hs_fall has no reference). On vs_fall go to SYNC and set good = 0. No error pulses are generated in HUNT.
  - SYNC:
    - A bad line or a bad frame: sync_err = 1, go to HUNT.
    - A good vs_fall: good++. If good + 1 == LOCK_FRAMES, go to LOCKED.
  - LOCKED:
    - A bad line or a bad frame: sync_err = 1, locked drops on the same edge as the sync_err pulse, go to HUNT.
    - A good vs_fall: frame_start = 1.
  - Entering LOCKED, the transition's own vs_fall also produces frame_start = 1.
  - locked = (state == LOCKED), registered.
- A bad line and a bad frame in the same sample produce a single sync_err pulse.
- Reset values: state = HUNT; every counter = 0; hs_prev = vs_prev = 1; all outputs = 0.
- Reset asserted mid-frame returns the block to HUNT on the next edge, and any in-progress pulse is suppressed.
- Saturation: h_cnt or v_cnt at 1023 stays at 1023, which guarantees a failed check. This covers a stalled HS or VS.

Test Plan:
- Ideal 640x480 stream, pix_ce every 2nd Clk, starting mid-frame -> locked rises with the 3rd VS fall; frame_start pulses on the 3rd and every later VS fall; sync_err never asserts.
- Locked stream, 1st active pixel of line 0 and last pixel of line 479 -> pix_valid with (rx_x, rx_y) = (0, 0) and (639, 479) one Clk after the sampling cycle; exactly 307200 pix_valid pulses per frame.
- Locked stream, one line shortened to 799 samples -> sync_err one-Clk pulse and locked = 0 at that HS fall; relock after 2 further good frames.
- Locked stream, one frame of 524 lines -> sync_err at the VS fall, no frame_start on that VS fall, state HUNT.
- hs_n held high for 2000 samples -> h_cnt saturates at 1023; the next HS fall flags sync_err; no pix_valid while unlocked.
- Reset for 1 Clk mid-frame while locked -> all outputs 0 on the next edge; relock takes exactly as long as from power-up.
